// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the IF stage and imem.
// master = fetch unit (issues requests), slave = memory (accepts and replies).
interface fetch_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;

  modport master (output req_valid, req_addr, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_addr, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/fetch_unit.sv
// RV32I IF stage: owns the PC, issues one word fetch at a time, buffers one
// extra instruction while IF/ID is stalled, and discards fetches killed by a
// redirect. Drives the IF/ID register (valid, pc, instr).
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  fetch_unit_if.master imem,
  output logic         if_id_valid_o,
  output logic [31:0]  if_id_pc_o,
  output logic [31:0]  if_id_instr_o
);

  typedef enum logic [1:0] {FETCH, WAIT, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        ifid_vld_q, ifid_vld_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;

  logic req_valid;
  logic fire;
  logic rsp_take;

  // Low address bits of a redirect target are dropped; keep them visibly sunk.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  // Request generation: only one outstanding fetch, and none while the skid
  // holds an instruction (so the skid can never be overwritten). Gating with
  // reset keeps the port quiet while reset is held.
  always_comb begin
    req_valid = reset_i && (state_q == FETCH) && !skid_vld_q && !redirect_i;
    fire      = req_valid && imem.req_ready;
    // A response is only meaningful while waiting on a live request; one that
    // lands in the redirect cycle belongs to a killed fetch.
    rsp_take  = (state_q == WAIT) && imem.rsp_valid && !redirect_i;
  end

  assign imem.req_valid = req_valid;
  assign imem.req_addr  = {pc_q[31:2], 2'b00};

  // Next-state for PC, fetch FSM, skid buffer and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_vld_d   = skid_vld_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    ifid_vld_d   = ifid_vld_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_instr_d = ifid_instr_q;

    if (redirect_i) begin
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      // Still owed a response (WAIT or DRAIN with nothing arriving): drain it.
      state_d    = ((state_q != FETCH) && !imem.rsp_valid) ? DRAIN : FETCH;
      ifid_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: if (fire) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = WAIT;
        end
        WAIT:    if (imem.rsp_valid) state_d = FETCH;
        DRAIN:   if (imem.rsp_valid) state_d = FETCH;
        default: state_d = FETCH;
      endcase

      if (stall_i && ifid_vld_q) begin
        // IF/ID held; the skid is empty here because no request issues
        // while it is full.
        if (rsp_take) begin
          skid_vld_d   = 1'b1;
          skid_pc_d    = req_pc_q;
          skid_instr_d = imem.rsp_data;
        end
      end else if (skid_vld_q) begin
        ifid_vld_d   = 1'b1;
        ifid_pc_d    = skid_pc_q;
        ifid_instr_d = skid_instr_q;
        if (rsp_take) begin
          skid_pc_d    = req_pc_q;
          skid_instr_d = imem.rsp_data;
        end else begin
          skid_vld_d = 1'b0;
        end
      end else if (rsp_take) begin
        ifid_vld_d   = 1'b1;
        ifid_pc_d    = req_pc_q;
        ifid_instr_d = imem.rsp_data;
      end else begin
        ifid_vld_d = 1'b0;
      end
    end
  end

  // State registers, asynchronously reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      skid_vld_q   <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      ifid_vld_q   <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      skid_vld_q   <= skid_vld_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      ifid_vld_q   <= ifid_vld_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign if_id_valid_o = ifid_vld_q;
  assign if_id_pc_o    = ifid_pc_q;
  assign if_id_instr_o = ifid_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a variable-latency memory model answers the DUT's
// requests; a transaction-level reference (PC, owed-response flag, queue of
// fetched-but-undelivered instructions) predicts the bus and IF/ID outputs.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        if_vld;
  logic [31:0] if_pc, if_instr;

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk_i         (clk),
    .reset_i       (rst_n),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (redir_pc),
    .imem          (imem_bus),
    .if_id_valid_o (if_vld),
    .if_id_pc_o    (if_pc),
    .if_id_instr_o (if_instr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // memory model
  bit          mem_busy = 0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = '0;
  bit          rdy_en = 1;
  bit          rdy_rand = 0;
  int          lat_sel = 1;   // 0 = random 1..4, else fixed latency

  // reference model
  logic [31:0] m_pc, m_pend_pc, m_ifpc, m_ifinstr;
  bit          m_pend, m_kill, m_vld;
  logic [31:0] skq[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0013_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_pend = 0; m_kill = 0; m_pend_pc = '0;
    m_vld = 0; m_ifpc = '0; m_ifinstr = NOP;
    skq.delete();
  endtask

  function automatic bit exp_rv();
    return rst_n && !m_pend && (skq.size() == 0) && !redir;
  endfunction

  // One clock: check at negedge, advance model and memory at posedge,
  // drive memory outputs for the next cycle just after the edge.
  task automatic tick();
    bit erv, fire_dut, fire_m, rsp, arriving, newv;
    logic [31:0] addr, npc;
    @(negedge clk);
    erv = exp_rv();
    chk("req_valid", {31'b0, imem_bus.req_valid}, {31'b0, erv});
    if (erv) chk("req_addr", imem_bus.req_addr, m_pc);
    chk("if_id_valid", {31'b0, if_vld}, {31'b0, m_vld});
    chk("if_id_pc", if_pc, m_ifpc);
    chk("if_id_instr", if_instr, m_ifinstr);
    fire_dut = imem_bus.req_valid && imem_bus.req_ready;
    fire_m   = erv && imem_bus.req_ready;
    rsp      = imem_bus.rsp_valid;
    addr     = imem_bus.req_addr;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      arriving = rsp && m_pend;
      newv     = arriving && !m_kill && !redir;
      npc      = m_pend_pc;
      if (redir) begin
        m_vld = 0; skq.delete();
        m_pc = {redir_pc[31:2], 2'b00};
        if (m_pend && !rsp) m_kill = 1; else m_pend = 0;
      end else begin
        if (arriving) m_pend = 0;
        if (fire_m) begin
          m_pend = 1; m_kill = 0; m_pend_pc = m_pc; m_pc = m_pc + 32'd4;
        end
        if (stall && m_vld) begin
          if (newv) skq.push_back(npc);
        end else if (skq.size() != 0) begin
          m_vld = 1; m_ifpc = skq.pop_front(); m_ifinstr = memf(m_ifpc);
          if (newv) skq.push_back(npc);
        end else if (newv) begin
          m_vld = 1; m_ifpc = npc; m_ifinstr = memf(npc);
        end else m_vld = 0;
      end
    end
    if (rsp) mem_busy = 0;
    else if (mem_busy && mem_cnt > 0) mem_cnt--;
    if (fire_dut) begin
      mem_busy = 1; mem_addr = addr;
      mem_cnt = (lat_sel == 0) ? int'($urandom_range(0, 3)) : lat_sel - 1;
    end
    #1;
    if (rdy_rand) rdy_en = bit'($urandom_range(0, 1));
    imem_bus.rsp_valid = mem_busy && (mem_cnt == 0);
    imem_bus.rsp_data  = imem_bus.rsp_valid ? memf(mem_addr) : $urandom;
    imem_bus.req_ready = rdy_en && !mem_busy;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ifid(input logic [31:0] pc);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = m_vld && (m_ifpc == pc);
    end
    chk("wait_ifid_bound", {31'b0, found}, 32'd1);
  endtask

  task automatic wait_pend(input logic [31:0] pc, input bit any);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = m_pend && !m_kill && (any || m_pend_pc == pc);
    end
    chk("wait_pend_bound", {31'b0, found}, 32'd1);
  endtask

  task automatic wait_skid();
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      found = (skq.size() == 1);
    end
    chk("wait_skid_bound", {31'b0, found}, 32'd1);
  endtask

  initial begin
    imem_bus.req_ready = 1'b0;
    imem_bus.rsp_valid = 1'b0;
    imem_bus.rsp_data  = '0;
    model_reset();

    // reset state, then stream at 1-cycle latency
    ticks(2);
    rst_n = 1'b1;
    ticks(1);
    wait_ifid(32'h104);

    // stall with IF/ID=0x104 while 0x108 returns into the skid
    stall = 1'b1;
    ticks(4);
    chk("skid_hold_pc", if_pc, 32'h104);
    stall = 1'b0;
    lat_sel = 3;

    // redirect while 0x110 is outstanding with 3-cycle latency
    wait_pend(32'h110, 0);
    redir = 1'b1; redir_pc = 32'h200;
    tick();
    redir = 1'b0;
    lat_sel = 1;
    wait_ifid(32'h200);
    ticks(3);

    // redirect together with stall and a full skid
    stall = 1'b1;
    wait_skid();
    redir = 1'b1; redir_pc = 32'h300;
    tick();
    redir = 1'b0;
    ticks(2);
    stall = 1'b0;
    wait_ifid(32'h304);

    // PC wrap, then a misaligned redirect target
    redir = 1'b1; redir_pc = 32'hFFFF_FFFC;
    tick();
    redir = 1'b0;
    wait_ifid(32'h0000_0000);
    redir = 1'b1; redir_pc = 32'h203;
    tick();
    redir = 1'b0;
    wait_ifid(32'h204);

    // async reset in the middle of a long wait; late response must be ignored
    lat_sel = 5;
    wait_pend(32'h0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_req_valid", {31'b0, imem_bus.req_valid}, 32'd0);
    chk("async_rst_if_valid", {31'b0, if_vld}, 32'd0);
    chk("async_rst_if_pc", if_pc, 32'd0);
    chk("async_rst_if_instr", if_instr, NOP);
    ticks(1);
    rst_n = 1'b1;
    lat_sel = 1;
    wait_ifid(RST_PC + 32'd4);

    // randomized traffic
    lat_sel = 0;
    rdy_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      redir    = ($urandom_range(0, 19) == 0);
      redir_pc = $urandom;
      tick();
    end
    stall = 1'b0; redir = 1'b0;
    ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
